// File: rtl/s_axis_rq_arbiter.sv
// s_axis_rq_arbiter
// Packet-granular round-robin arbiter that shares one PCIe requester-request
// AXI-Stream port between NUM_REQ TLP sources. A grant is held from the first
// beat of a packet to its tlast beat, so downstream always sees whole TLPs.
//
// Optional build macro S_AXIS_RQ_ARB_OUTREG_EN: inserts a 2-entry skid buffer
// on the m_axis_rq_* outputs. Upstream ready then follows buffer "not full",
// arbitration advances on the upstream transfer and the first beat appears one
// cycle after it is accepted. Without the macro the outputs are a
// combinational pass-through of the selected requester.
//
// Handshake: a beat moves on any AXI-Stream interface only in a cycle where
// tvalid and tready are both high; a source holds tvalid and its payload
// stable until that happens, and tready never depends on the same-cycle
// tvalid of a non-granted source.
module s_axis_rq_arbiter #(
   parameter int DATA_WIDTH = 128,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int NUM_REQ    = 2,
   parameter int IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                          user_clk,
   input  logic                          user_reset_n,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] s_req_tdata,
   input  logic [NUM_REQ*KEEP_WIDTH-1:0] s_req_tkeep,
   input  logic [NUM_REQ-1:0]            s_req_tlast,
   input  logic [NUM_REQ*4-1:0]          s_req_tuser,
   input  logic [NUM_REQ-1:0]            s_req_tvalid,
   output logic [NUM_REQ-1:0]            s_req_tready,
   output logic [DATA_WIDTH-1:0]         m_axis_rq_tdata,
   output logic [KEEP_WIDTH-1:0]         m_axis_rq_tkeep,
   output logic                          m_axis_rq_tlast,
   output logic [3:0]                    m_axis_rq_tuser,
   output logic                          m_axis_rq_tvalid,
   input  logic                          m_axis_rq_tready,
   output logic [IDX_W-1:0]              grant_id,
   output logic                          grant_busy
);

   localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1 + 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_rr_ptr;
   logic [IDX_W-1:0] r_grant_id;
   logic [IDX_W-1:0] r_hold_idx;
   logic             r_hold_valid;

   logic [IDX_W-1:0]   w_winner;
   logic               w_any_valid;
   logic [IDX_W-1:0]   w_sel;
   logic               w_sel_valid;
   logic               w_sel_last;
   logic               w_grant_live;
   logic               w_dn_ready;
   logic               w_xfer;
   logic [IDX_W-1:0]   w_next_ptr;
   logic [PW-1:0]      w_sel_payload;
   logic [NUM_REQ-1:0] w_tready;

   // Round-robin search over tvalid, starting at rr_ptr and wrapping modulo NUM_REQ
   always_comb begin
      w_winner    = r_rr_ptr;
      w_any_valid = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_any_valid && s_req_tvalid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
            w_winner    = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            w_any_valid = 1'b1;
         end
      end
   end

   // Selection: locked owner in BUSY, frozen pick while a stalled beat waits, else the live winner
   always_comb begin
      if (r_state == ST_BUSY)
         w_sel = r_grant_id;
      else if (r_hold_valid)
         w_sel = r_hold_idx;
      else
         w_sel = w_winner;
   end

   // Reset gates valid/ready directly so the port goes quiet without waiting for a clock edge
   assign w_sel_valid   = user_reset_n & s_req_tvalid[w_sel];
   assign w_sel_last    = s_req_tlast[w_sel];
   assign w_grant_live  = user_reset_n & ((r_state == ST_BUSY) | w_sel_valid);
   assign w_xfer        = w_sel_valid & w_dn_ready;
   assign w_next_ptr    = (w_sel == IDX_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
   assign w_sel_payload = {s_req_tdata[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH],
                           s_req_tkeep[int'(w_sel)*KEEP_WIDTH +: KEEP_WIDTH],
                           w_sel_last,
                           s_req_tuser[int'(w_sel)*4 +: 4]};

   // Only the selected requester ever sees ready; all others are held off
   always_comb begin
      w_tready = '0;
      if (w_grant_live)
         w_tready[w_sel] = w_dn_ready;
   end

   assign s_req_tready = w_tready;

   // Arbitration FSM: packet ownership, round-robin pointer and stall freeze
   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         r_state      <= ST_IDLE;
         r_rr_ptr     <= '0;
         r_grant_id   <= '0;
         r_hold_idx   <= '0;
         r_hold_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_xfer) begin
                  r_hold_valid <= 1'b0;
                  r_grant_id   <= w_sel;
                  if (w_sel_last)
                     r_rr_ptr <= w_next_ptr;
                  else
                     r_state <= ST_BUSY;
               end else if (w_sel_valid) begin
                  r_hold_valid <= 1'b1;
                  r_hold_idx   <= w_sel;
               end
            end
            ST_BUSY: begin
               if (w_xfer && w_sel_last) begin
                  r_state  <= ST_IDLE;
                  r_rr_ptr <= w_next_ptr;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign grant_id   = r_grant_id;
   assign grant_busy = (r_state == ST_BUSY);

`ifdef S_AXIS_RQ_ARB_OUTREG_EN
   logic [PW-1:0] r_buf [2];
   logic          r_wr_ptr;
   logic          r_rd_ptr;
   logic [1:0]    r_count;
   logic          w_pop;

   assign w_dn_ready = (r_count != 2'd2);
   assign w_pop      = (r_count != 2'd0) & m_axis_rq_tready;

   // Two-entry skid buffer: accepts whenever an entry is free, drains on downstream ready
   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         r_buf[0] <= '0;
         r_buf[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_xfer) begin
            r_buf[r_wr_ptr] <= w_sel_payload;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         case ({w_xfer, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign {m_axis_rq_tdata, m_axis_rq_tkeep, m_axis_rq_tlast, m_axis_rq_tuser} = r_buf[r_rd_ptr];
   assign m_axis_rq_tvalid = (r_count != 2'd0);
`else
   assign w_dn_ready = m_axis_rq_tready;
   assign {m_axis_rq_tdata, m_axis_rq_tkeep, m_axis_rq_tlast, m_axis_rq_tuser} = w_sel_payload;
   assign m_axis_rq_tvalid = w_sel_valid;
`endif

endmodule

// File: tb/tb_s_axis_rq_arbiter.sv
// tb_s_axis_rq_arbiter
// Directed bench for s_axis_rq_arbiter in its default (pass-through) build:
// a 2-requester instance walks reset, multi-beat ownership, bubbles, stalls
// and mid-packet reset; a 4-requester instance checks round-robin order.
module tb_s_axis_rq_arbiter;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic user_reset_n;
   always #5 clk = ~clk;

   // ---------------- 2-requester DUT ----------------
   logic [7:0]   req_tag [2];
   logic [1:0]   req_v;
   logic [1:0]   req_l;
   logic [255:0] s_tdata;
   logic [31:0]  s_tkeep;
   logic [7:0]   s_tuser;
   logic [1:0]   s_tready;
   logic [127:0] m_tdata;
   logic [15:0]  m_tkeep;
   logic         m_tlast;
   logic [3:0]   m_tuser;
   logic         m_tvalid;
   logic         m_tready;
   logic [0:0]   gid;
   logic         gbusy;

   assign s_tdata = {120'h0, req_tag[1], 120'h0, req_tag[0]};
   assign s_tkeep = '1;
   assign s_tuser = {req_tag[1][3:0], req_tag[0][3:0]};

   s_axis_rq_arbiter #(.DATA_WIDTH(128), .NUM_REQ(2)) u_dut (
      .user_clk         (clk),
      .user_reset_n     (user_reset_n),
      .s_req_tdata      (s_tdata),
      .s_req_tkeep      (s_tkeep),
      .s_req_tlast      (req_l),
      .s_req_tuser      (s_tuser),
      .s_req_tvalid     (req_v),
      .s_req_tready     (s_tready),
      .m_axis_rq_tdata  (m_tdata),
      .m_axis_rq_tkeep  (m_tkeep),
      .m_axis_rq_tlast  (m_tlast),
      .m_axis_rq_tuser  (m_tuser),
      .m_axis_rq_tvalid (m_tvalid),
      .m_axis_rq_tready (m_tready),
      .grant_id         (gid),
      .grant_busy       (gbusy)
   );

   // ---------------- 4-requester DUT ----------------
   logic [511:0] s4_tdata;
   logic [63:0]  s4_tkeep;
   logic [15:0]  s4_tuser;
   logic [3:0]   s4_tvalid;
   logic [3:0]   s4_tready;
   logic [127:0] m4_tdata;
   logic [15:0]  m4_tkeep;
   logic         m4_tlast;
   logic [3:0]   m4_tuser;
   logic         m4_tvalid;
   logic [1:0]   gid4;
   logic         gbusy4;

   assign s4_tdata = {128'h3, 128'h2, 128'h1, 128'h0};
   assign s4_tkeep = '1;
   assign s4_tuser = 16'h3210;

   s_axis_rq_arbiter #(.DATA_WIDTH(128), .NUM_REQ(4)) u_dut4 (
      .user_clk         (clk),
      .user_reset_n     (user_reset_n),
      .s_req_tdata      (s4_tdata),
      .s_req_tkeep      (s4_tkeep),
      .s_req_tlast      (4'hF),
      .s_req_tuser      (s4_tuser),
      .s_req_tvalid     (s4_tvalid),
      .s_req_tready     (s4_tready),
      .m_axis_rq_tdata  (m4_tdata),
      .m_axis_rq_tkeep  (m4_tkeep),
      .m_axis_rq_tlast  (m4_tlast),
      .m_axis_rq_tuser  (m4_tuser),
      .m_axis_rq_tvalid (m4_tvalid),
      .m_axis_rq_tready (1'b1),
      .grant_id         (gid4),
      .grant_busy       (gbusy4)
   );

   // ---------------- scoreboard counters ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input int i, input logic v, input logic l, input logic [7:0] t);
      req_v[i]   = v;
      req_l[i]   = l;
      req_tag[i] = t;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output beat and per-requester ready expected for this cycle
   task automatic look(input string nm, input logic ev, input logic [7:0] et,
                       input logic el, input logic [1:0] er);
      check({nm, "_tvalid"}, {127'h0, m_tvalid}, {127'h0, ev});
      if (ev) begin
         check({nm, "_tdata"}, m_tdata, {120'h0, et});
         check({nm, "_tlast"}, {127'h0, m_tlast}, {127'h0, el});
         check({nm, "_tuser"}, {124'h0, m_tuser}, {124'h0, et[3:0]});
      end
      check({nm, "_tready"}, {126'h0, s_tready}, {126'h0, er});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      user_reset_n = 1'b0;
      m_tready     = 1'b1;
      s4_tvalid    = 4'h0;
      drive(0, 1'b1, 1'b0, 8'h01);
      drive(1, 1'b1, 1'b1, 8'h11);

      // reset held with both requesters valid
      #3;
      check("rst_tvalid", {127'h0, m_tvalid}, 128'h0);
      check("rst_tready", {126'h0, s_tready}, 128'h0);
      check("rst_busy",   {127'h0, gbusy},    128'h0);
      check("rst_gid",    {127'h0, gid},      128'h0);
      @(posedge clk);
      @(posedge clk);
      #1 user_reset_n = 1'b1;
      #2;

      // req0 3-beat packet, req1 single beat waiting
      look("p0b1", 1'b1, 8'h01, 1'b0, 2'b01);
      check("p0b1_gid", {127'h0, gid}, 128'h0);
      tick(); drive(0, 1'b1, 1'b0, 8'h02); #2;
      look("p0b2", 1'b1, 8'h02, 1'b0, 2'b01);
      check("p0b2_busy", {127'h0, gbusy}, 128'h1);
      tick(); drive(0, 1'b1, 1'b1, 8'h03); #2;
      look("p0b3", 1'b1, 8'h03, 1'b1, 2'b01);
      tick(); drive(0, 1'b1, 1'b1, 8'h04); #2;
      look("p1", 1'b1, 8'h11, 1'b1, 2'b10);
      check("p1_busy", {127'h0, gbusy}, 128'h0);
      tick(); drive(1, 1'b0, 1'b0, 8'h00); #2;
      look("rr0", 1'b1, 8'h04, 1'b1, 2'b01);
      check("rr0_gid", {127'h0, gid}, 128'h1);

      // req1 packet with a 2-cycle bubble while req0 waits
      tick(); drive(1, 1'b1, 1'b0, 8'h21); drive(0, 1'b1, 1'b1, 8'h05); #2;
      look("bb_b1", 1'b1, 8'h21, 1'b0, 2'b10);
      tick(); drive(1, 1'b0, 1'b0, 8'h22); #2;
      look("bb_gap1", 1'b0, 8'h00, 1'b0, 2'b10);
      check("bb_busy", {127'h0, gbusy}, 128'h1);
      tick(); #2;
      look("bb_gap2", 1'b0, 8'h00, 1'b0, 2'b10);
      tick(); drive(1, 1'b1, 1'b1, 8'h22); #2;
      look("bb_b2", 1'b1, 8'h22, 1'b1, 2'b10);
      tick(); drive(1, 1'b0, 1'b0, 8'h00); #2;
      look("bb_r0", 1'b1, 8'h05, 1'b1, 2'b01);

      // downstream stall in IDLE: selection frozen on req0
      tick(); drive(0, 1'b1, 1'b1, 8'h06); m_tready = 1'b0; #2;
      look("st0", 1'b1, 8'h06, 1'b1, 2'b00);
      tick(); drive(1, 1'b1, 1'b1, 8'h31); #2;
      look("st1", 1'b1, 8'h06, 1'b1, 2'b00);
      for (int c = 2; c < 5; c++) begin
         tick(); #2;
         look($sformatf("st%0d", c), 1'b1, 8'h06, 1'b1, 2'b00);
      end
      tick(); m_tready = 1'b1; #2;
      look("st_go", 1'b1, 8'h06, 1'b1, 2'b01);
      tick(); drive(0, 1'b0, 1'b0, 8'h00); #2;
      look("st_r1", 1'b1, 8'h31, 1'b1, 2'b10);

      // mid-packet reset with rr_ptr pointing at req1
      tick(); drive(1, 1'b0, 1'b0, 8'h00); drive(0, 1'b1, 1'b1, 8'h40); #2;
      look("mr_r0", 1'b1, 8'h40, 1'b1, 2'b01);
      tick(); drive(0, 1'b0, 1'b0, 8'h00); drive(1, 1'b1, 1'b0, 8'h41); #2;
      look("mr_b1", 1'b1, 8'h41, 1'b0, 2'b10);
      tick(); drive(1, 1'b1, 1'b0, 8'h42); drive(0, 1'b1, 1'b0, 8'h51); #2;
      look("mr_b2", 1'b1, 8'h42, 1'b0, 2'b10);
      check("mr_gid1", {127'h0, gid}, 128'h1);
      #1 user_reset_n = 1'b0;
      #1;
      check("mr_async_tvalid", {127'h0, m_tvalid}, 128'h0);
      check("mr_async_busy",   {127'h0, gbusy},    128'h0);
      check("mr_async_gid",    {127'h0, gid},      128'h0);
      check("mr_async_tready", {126'h0, s_tready}, 128'h0);
      tick(); user_reset_n = 1'b1; drive(1, 1'b1, 1'b0, 8'h61); #2;
      look("mr_after", 1'b1, 8'h51, 1'b0, 2'b01);
      check("mr_after_gid", {127'h0, gid}, 128'h0);
      tick(); drive(0, 1'b0, 1'b0, 8'h00); drive(1, 1'b0, 1'b0, 8'h00);

      // four requesters, all sending single-beat packets
      s4_tvalid = 4'hF;
      #2;
      for (int c = 0; c < 5; c++) begin
         check($sformatf("rr4_%0d_tvalid", c), {127'h0, m4_tvalid}, 128'h1);
         check($sformatf("rr4_%0d_src", c), m4_tdata, 128'(c % 4));
         check($sformatf("rr4_%0d_tready", c), {124'h0, s4_tready}, 128'(1 << (c % 4)));
         tick(); #2;
      end
      s4_tvalid = 4'h0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
